// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: L1 miss-handling controller.
// On a miss, latches the block base address and streams one word read per
// cycle to the pipelined main memory. Each returned word goes straight into
// the cache data array. The tag/valid write fires together with the last
// word. The controller counts returned words rather than timing them, so
// gaps in the memory response stream are tolerated.
module cache_fill_fsm #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic        memory_data_valid,
    input  logic [15:0] memory_data,
    output logic        fsm_busy,
    output logic        mem_en,
    output logic [15:0] memory_address,
    output logic        write_data_array,
    output logic [2:0]  fill_word_idx,
    output logic [15:0] fill_data,
    output logic        write_tag_array,
    output logic [15:0] fill_base
);

    // Word index width, and the issue counter needs one extra bit to hold
    // the saturated "all requests sent" value.
    localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
    localparam int CNT_W = IDX_W + 1;
    // Byte offset bits within a block (16-bit words, byte addressed).
    localparam int OFF_W = IDX_W + 1;

    localparam logic [CNT_W-1:0] ISSUE_DONE = CNT_W'(WORDS_PER_BLOCK);
    localparam logic [IDX_W-1:0] LAST_WORD  = IDX_W'(WORDS_PER_BLOCK - 1);
    localparam logic [15:0]      BASE_MASK  = ~16'((1 << OFF_W) - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   issue_cnt;
    logic [IDX_W-1:0]   recv_cnt;
    logic [15:0]        base_q;
    logic               issue_active;

    // Requests go out until every word of the block has been asked for.
    assign issue_active = (state == FILL) && (issue_cnt < ISSUE_DONE);

    // Returned data is written untouched; the base is exported for index/tag.
    assign fill_data = memory_data;
    assign fill_base = base_q;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: leave FILL only when the last word of the block lands.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (miss_detected) state_next = FILL;
            FILL: if (memory_data_valid && (recv_cnt == LAST_WORD)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Fill datapath: latch the block base on a miss, count issued and
    // received words during the fill. A new miss is only taken from IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q    <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else if (state == IDLE) begin
            if (miss_detected) begin
                base_q    <= miss_address & BASE_MASK;
                issue_cnt <= '0;
                recv_cnt  <= '0;
            end
        end else begin
            if (issue_active) begin
                issue_cnt <= issue_cnt + 1'b1;
            end
            if (memory_data_valid) begin
                recv_cnt <= recv_cnt + 1'b1;
            end
        end
    end

    // Output decode from state and counters; everything is quiet in IDLE.
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        fsm_busy         = 1'b0;
        mem_en           = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        fill_word_idx    = '0;
        write_tag_array  = 1'b0;
        if (state == FILL) begin
            fsm_busy       = 1'b1;
            mem_en         = issue_active;
            memory_address = base_q + 16'({issue_cnt, 1'b0});
            if (memory_data_valid) begin
                write_data_array = 1'b1;
                fill_word_idx    = 3'(recv_cnt);
                write_tag_array  = (recv_cnt == LAST_WORD);
            end
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Testbench for cache_fill_fsm: a table-driven basic fill, followed by
// hand-written sequences for the multi-cycle corner cases. A small
// 4-cycle-latency memory returns data equal to the requested address.
// Alternatively, the stimulus drives memory returns by hand.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        fsm_busy;
    logic        mem_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  fill_word_idx;
    logic [15:0] fill_data;
    logic        write_tag_array;
    logic [15:0] fill_base;

    int n_vec = 0;
    int n_err = 0;

    // Memory source select: automatic model or manual drive.
    bit          mem_auto  = 1'b1;
    bit          man_valid = 1'b0;
    logic [15:0] man_data  = '0;

    // Memory model: a request in cycle N returns in cycle N+3.
    logic [16:0] p0 = '0;
    logic [16:0] p1 = '0;
    logic [16:0] p2 = '0;

    always @(posedge clk) begin
        p0 <= {mem_en, memory_address};
        p1 <= p0;
        p2 <= p1;
    end

    assign memory_data_valid = mem_auto ? p2[16]    : man_valid;
    assign memory_data       = mem_auto ? p2[15:0]  : man_data;

    always #5 clk = ~clk;

    cache_fill_fsm #(.WORDS_PER_BLOCK(8), .MEM_LATENCY(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .mem_en            (mem_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_word_idx     (fill_word_idx),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array),
        .fill_base         (fill_base)
    );

    typedef struct {
        logic        miss;
        logic [15:0] maddr;
        logic        e_busy;
        logic        e_en;
        logic [15:0] e_addr;
        logic        e_wda;
        logic [2:0]  e_idx;
        logic        e_wta;
        logic [15:0] e_base;
        logic [15:0] e_data;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input int k,
                         input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, k, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle of stimulus, check outputs mid-cycle, then advance.
    task automatic apply_vec(input vec_t v, input string tag, input int k);
        miss_detected = v.miss;
        miss_address  = v.maddr;
        #1;
        check({tag, ".busy"}, k, 32'(fsm_busy), 32'(v.e_busy));
        check({tag, ".mem_en"}, k, 32'(mem_en), 32'(v.e_en));
        if (v.e_en || !v.e_busy)
            check({tag, ".addr"}, k, 32'(memory_address), 32'(v.e_addr));
        check({tag, ".wda"}, k, 32'(write_data_array), 32'(v.e_wda));
        if (v.e_wda || !v.e_busy)
            check({tag, ".idx"}, k, 32'(fill_word_idx), 32'(v.e_idx));
        check({tag, ".wta"}, k, 32'(write_tag_array), 32'(v.e_wta));
        check({tag, ".base"}, k, 32'(fill_base), 32'(v.e_base));
        if (v.e_wda)
            check({tag, ".data"}, k, 32'(fill_data), 32'(v.e_data));
        tick();
    endtask

    // One fill against the auto memory, T0 (miss cycle) through T12.
    // hold_from: miss_detected stays high with other_addr from that cycle
    // up to T11. chain: stop after T11 so the caller starts the next fill.
    task automatic run_auto_fill(input logic [15:0] maddr, input logic [15:0] base,
                                 input logic [15:0] prev_base, input int hold_from,
                                 input logic [15:0] other_addr, input bit chain,
                                 input string tag);
        vec_t v;
        int   last_k;
        last_k = chain ? 11 : 12;
        for (int k = 0; k <= last_k; k++) begin
            v.miss   = (k == 0) || (k >= hold_from && k <= 11);
            v.maddr  = (k == 0) ? maddr : other_addr;
            v.e_busy = (k >= 1 && k <= 11);
            v.e_en   = (k >= 1 && k <= 8);
            v.e_addr = v.e_en ? base + 16'(2 * (k - 1)) : 16'h0000;
            v.e_wda  = (k >= 4 && k <= 11);
            v.e_idx  = v.e_wda ? 3'(k - 4) : 3'd0;
            v.e_wta  = (k == 11);
            v.e_base = (k == 0) ? prev_base : base;
            v.e_data = base + 16'(2 * (k - 4));
            apply_vec(v, tag, k);
        end
        miss_detected = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int en_cnt;
        bit vld;

        // Basic fill: miss at 0x1236, data = address, 4-cycle latency.
        //           miss maddr    busy en addr     wda idx wta base     data
        tbl[0]  = '{1'b1, 16'h1236, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0, 16'h0000, 16'h0000};
        tbl[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h1230, 1'b0, 3'd0, 1'b0, 16'h1230, 16'h0000};
        tbl[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h1232, 1'b0, 3'd0, 1'b0, 16'h1230, 16'h0000};
        tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234, 1'b0, 3'd0, 1'b0, 16'h1230, 16'h0000};
        tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h1236, 1'b1, 3'd0, 1'b0, 16'h1230, 16'h1230};
        tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h1238, 1'b1, 3'd1, 1'b0, 16'h1230, 16'h1232};
        tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h123A, 1'b1, 3'd2, 1'b0, 16'h1230, 16'h1234};
        tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h123C, 1'b1, 3'd3, 1'b0, 16'h1230, 16'h1236};
        tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h123E, 1'b1, 3'd4, 1'b0, 16'h1230, 16'h1238};
        tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd5, 1'b0, 16'h1230, 16'h123A};
        tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd6, 1'b0, 16'h1230, 16'h123C};
        tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd7, 1'b1, 16'h1230, 16'h123E};
        tbl[12] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0, 16'h1230, 16'h0000};

        // Reset, with a simultaneous miss: reset must win.
        rst           = 1'b1;
        miss_detected = 1'b1;
        miss_address  = 16'h5555;
        tick();
        tick();
        check("reset.busy", 0, 32'(fsm_busy), 32'd0);
        check("reset.mem_en", 0, 32'(mem_en), 32'd0);
        check("reset.addr", 0, 32'(memory_address), 32'd0);
        check("reset.wda", 0, 32'(write_data_array), 32'd0);
        check("reset.wta", 0, 32'(write_tag_array), 32'd0);
        check("reset.base", 0, 32'(fill_base), 32'd0);
        miss_detected = 1'b0;
        rst           = 1'b0;
        tick();
        check("reset.idle_busy", 0, 32'(fsm_busy), 32'd0);

        // Basic fill from the table.
        for (int k = 0; k < 13; k++) apply_vec(tbl[k], "basic", k);

        // Spurious miss at 0x4000 held through the whole fill.
        run_auto_fill(16'h1236, 16'h1230, 16'h1230, 1, 16'h4000, 1'b0, "spur_miss");

        // Valid pulses in IDLE must not write anything.
        mem_auto = 1'b0;
        for (int k = 0; k < 3; k++) begin
            man_valid = 1'b1;
            man_data  = 16'hBEEF;
            #1;
            check("idle_vld.wda", k, 32'(write_data_array), 32'd0);
            check("idle_vld.wta", k, 32'(write_tag_array), 32'd0);
            check("idle_vld.busy", k, 32'(fsm_busy), 32'd0);
            check("idle_vld.idx", k, 32'(fill_word_idx), 32'd0);
            check("idle_vld.pass", k, 32'(fill_data), 32'h0000BEEF);
            tick();
        end
        man_valid = 1'b0;
        tick();
        mem_auto = 1'b1;

        // Top of memory: 0xFFF0..0xFFFE, no wrap.
        run_auto_fill(16'hFFFF, 16'hFFF0, 16'h1230, 99, 16'h0000, 1'b0, "top");

        // Gapped returns: valids on alternate cycles T4, T6 ... T18.
        mem_auto = 1'b0;
        en_cnt   = 0;
        for (int k = 0; k <= 19; k++) begin
            miss_detected = (k == 0);
            miss_address  = (k == 0) ? 16'h2008 : 16'h0000;
            vld           = (k >= 4) && (k <= 18) && (((k - 4) % 2) == 0);
            man_valid     = vld;
            man_data      = 16'hA000 + 16'((k - 4) / 2);
            #1;
            if (mem_en) en_cnt++;
            check("gap.busy", k, 32'(fsm_busy), 32'(k >= 1 && k <= 18));
            check("gap.wda", k, 32'(write_data_array), 32'(vld));
            check("gap.wta", k, 32'(write_tag_array), 32'(k == 18));
            if (k >= 1 && k <= 8)
                check("gap.addr", k, 32'(memory_address), 32'(16'h2000 + 16'(2 * (k - 1))));
            if (vld) begin
                check("gap.idx", k, 32'(fill_word_idx), 32'((k - 4) / 2));
                check("gap.data", k, 32'(fill_data), 32'(16'hA000 + 16'((k - 4) / 2)));
            end
            tick();
        end
        check("gap.mem_en_cycles", 0, 32'(en_cnt), 32'd8);
        man_valid = 1'b0;
        mem_auto  = 1'b1;

        // Reset mid-fill: rst high in T6, IDLE in T7, no tag write ever.
        for (int k = 0; k <= 9; k++) begin
            miss_detected = (k == 0);
            miss_address  = (k == 0) ? 16'h3004 : 16'h0000;
            rst           = (k == 6);
            #1;
            check("rst_mid.wta", k, 32'(write_tag_array), 32'd0);
            if (k >= 1 && k <= 6) begin
                check("rst_mid.busy", k, 32'(fsm_busy), 32'd1);
                check("rst_mid.addr", k, 32'(memory_address), 32'(16'h3000 + 16'(2 * (k - 1))));
            end
            if (k == 6)
                check("rst_mid.idx", k, 32'(fill_word_idx), 32'd2);
            if (k >= 7) begin
                check("rst_mid.busy", k, 32'(fsm_busy), 32'd0);
                check("rst_mid.mem_en", k, 32'(mem_en), 32'd0);
                check("rst_mid.addr", k, 32'(memory_address), 32'd0);
                check("rst_mid.wda", k, 32'(write_data_array), 32'd0);
                check("rst_mid.idx", k, 32'(fill_word_idx), 32'd0);
                check("rst_mid.base", k, 32'(fill_base), 32'd0);
            end
            tick();
        end
        rst = 1'b0;
        run_auto_fill(16'h0020, 16'h0020, 16'h0000, 99, 16'h0000, 1'b0, "after_rst");

        // Back-to-back: second miss at 0x0040 held from T11, taken at T12.
        run_auto_fill(16'h0008, 16'h0000, 16'h0020, 11, 16'h0040, 1'b1, "b2b_first");
        run_auto_fill(16'h0040, 16'h0040, 16'h0000, 99, 16'h0000, 1'b0, "b2b_second");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller between an L1 cache (I-cache or D-cache instance) and the shared 4-cycle-latency pipelined main memory. On a miss it fetches the full 16-byte block as eight sequential word reads, one issued per cycle. It writes each returned word into the cache data array and updates the tag array when the last word lands. One instance sits inside each cache's memory interface; the cache arbiter gates its `mem_en` onto the memory port.

## Interface
Parameters:
- `WORDS_PER_BLOCK`, default 8: words per cache block. Must be a power of two.
- `MEM_LATENCY`, default 4: cycles from request to `memory_data_valid`. Informational only; the FSM counts valid pulses and does not time them.

Ports:
- `clk` in 1: clock, all state updates on the rising edge.
- `rst` in 1: synchronous active-high reset.
- `miss_detected` in 1: the cache reports a miss this cycle.
- `miss_address` in 16: byte address of the missing access.
- `memory_data_valid` in 1: main memory is returning one word this cycle.
- `memory_data` in 16: returned word.
- `fsm_busy` out 1: a fill is in progress; the cache stalls the pipeline.
- `mem_en` out 1: read request to memory this cycle. This block never writes memory.
- `memory_address` out 16: byte address of the current read request.
- `write_data_array` out 1: write `fill_data` into word `fill_word_idx` of the block.
- `fill_word_idx` out 3: word index within the block.
- `fill_data` out 16: data to write. Combinational pass-through of `memory_data`.
- `write_tag_array` out 1: one-cycle pulse to write the tag and set the valid bit for the block.
- `fill_base` out 16: latched block base address, used by the cache for the index and tag.

## Operation
- States: IDLE and FILL.
- IDLE → FILL on a rising edge with `miss_detected`=1. At that edge:
  - `fill_base` ← `miss_address & 16'hFFF0`.
  - `issue_cnt` ← 0.
  - `recv_cnt` ← 0.
- In FILL:
  - `mem_en` = (`issue_cnt` < 8).
  - `memory_address` = `fill_base` + 2·`issue_cnt` (16-bit add, byte-addressed words).
  - `issue_cnt` increments each cycle while `mem_en`=1 and saturates at 8.
- Each FILL cycle with `memory_data_valid`=1:
  - `write_data_array`=1 and `fill_word_idx` = `recv_cnt[2:0]`.
  - `recv_cnt` increments.
- On the valid cycle where `recv_cnt`=7: `write_data_array`=1 and `write_tag_array`=1 together, and the next state is IDLE.
- `fsm_busy` = (state == FILL). It is decoded from state, so it is low in the cycle in which `miss_detected` first rises.
- `miss_detected` is ignored in FILL; no re-latch occurs.
- `memory_data_valid` is ignored in IDLE: no array write, no counter change.
- `miss_address[3:0]` is ignored. The fill always starts at word 0, not critical-word-first.
- Base 16'hFFF0 fetches 0xFFF0 through 0xFFFE. No carry is possible past bit 3, so no wrap occurs.
- `mem_en`, `memory_address`, `write_*` and `fill_word_idx` are all 0 in IDLE.

## Timing
- Let T0 be the edge that samples the miss. FILL occupies cycles T1 onward.
- Requests are issued in cycles T1–T8 at addresses base+0 … base+14.
- With `MEM_LATENCY`=4, data is valid in cycles T4–T11. This means `memory_data_valid` rises 3 cycles after the request cycle, per memory4c.
- `write_tag_array` pulses in cycle T11. State is IDLE from T12.
- `fsm_busy` is high in cycles T1–T11: 11 cycles total.
- A new miss is accepted at the T12 edge at the earliest.
- Gaps in `memory_data_valid` are tolerated: the fill completes on the 8th valid, whenever it arrives.
- Reset (`rst`=1 at an edge, in any state):
  - state = IDLE, counters = 0, `fill_base` = 0.
  - All registered outputs are 0 in the following cycle.
  - A reset mid-fill issues no tag write. Partial data-array writes remain but are invalid because the valid bit is never set.
- If `rst` and `miss_detected` are both high at an edge, reset wins.

## Test plan
- **Basic fill.** Miss at 0x1236, memory returning data = address with 4-cycle latency.
  - `memory_address` is 0x1230, 0x1232 … 0x123E in T1–T8.
  - `write_data_array` is high in T4–T11 with idx 0–7 and data 0x1230 … 0x123E.
  - Single `write_tag_array` in T11, `fill_base`=0x1230, `fsm_busy` low at T12.
- **Top of memory.** Miss at 0xFFFF → addresses 0xFFF0 … 0xFFFE, no wrap to 0x0000.
- **Spurious inputs.**
  - `miss_detected` held high for the whole fill at a different address (0x4000) → `fill_base` stays 0x1230.
  - `memory_data_valid` pulsed while in IDLE → no `write_data_array`.
- **Gapped returns.** Valids delivered on alternate cycles → 8 writes with idx 0–7 in order. Tag pulse coincides with the 8th write. `mem_en` still covers exactly 8 cycles.
- **Reset mid-fill.** `rst` asserted at T6 → IDLE at T7, all outputs 0, no `write_tag_array`. A subsequent miss at 0x0020 fills cleanly from word 0.
- **Back-to-back misses.** A second miss at 0x0040 held from T11 → accepted at the T12 edge. FILL resumes at T13, and `fsm_busy` is low for exactly one cycle (T12).
